sync_fifo_checker: RTL and testbench

SYNC_FIFO_CHECKER -- requirements
Module: sync_fifo_checker

---
 rtl/fifo_chk_pkg.sv | 33 +++
 rtl/fifo_chk_model.sv | 57 +++++
 rtl/sync_fifo_checker.sv | 96 +++++++++
 tb/tb_sync_fifo_checker.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/fifo_chk_pkg.sv
// rtl/fifo_chk_pkg.sv - error codes and priority encoder for the sync FIFO checker
package fifo_chk_pkg;

    typedef enum logic [2:0] {
        ERR_NONE       = 3'd0,
        ERR_DATA       = 3'd1,
        ERR_BOTH_FLAGS = 3'd2,
        ERR_EMPTY      = 3'd3,
        ERR_FULL       = 3'd4,
        ERR_OVERFLOW   = 3'd5,
        ERR_UNDERFLOW  = 3'd6
    } err_code_e;

    typedef struct packed {
        logic data;
        logic both_flags;
        logic empty;
        logic full;
        logic overflow;
        logic underflow;
    } fail_vec_t;

    function automatic err_code_e prio_encode(input fail_vec_t f);
        if (f.data)       return ERR_DATA;
        if (f.both_flags) return ERR_BOTH_FLAGS;
        if (f.empty)      return ERR_EMPTY;
        if (f.full)       return ERR_FULL;
        if (f.overflow)   return ERR_OVERFLOW;
        if (f.underflow)  return ERR_UNDERFLOW;
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/fifo_chk_model.sv
// rtl/fifo_chk_model.sv - shadow FIFO: memory, wrapping pointers and occupancy count
module fifo_chk_model
    import fifo_chk_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             write_i,
    input  logic             read_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             wr_ok_o,
    output logic             rd_ok_o,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;

    assign wr_ok_o = write_i && (count_q != CW'(DEPTH));
    assign rd_ok_o = read_i  && (count_q != '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        case ({wr_ok_o, rd_ok_o})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok_o) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_ok_o) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok_o) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/sync_fifo_checker.sv
// rtl/sync_fifo_checker.sv - bindable protocol/data checker for a synchronous FIFO
module sync_fifo_checker
    import fifo_chk_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 16,
    parameter int RD_LATENCY = 1,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   write,
    input  logic                   read,
    input  logic [WIDTH-1:0]       wData,
    input  logic [WIDTH-1:0]       rdData,
    input  logic                   empty,
    input  logic                   full,
    output logic                   err_valid,
    output err_code_e              err_code,
    output err_code_e              first_err,
    output logic [CNT_W-1:0]       err_count,
    output logic [$clog2(DEPTH):0] model_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic             wr_ok, rd_ok;
    logic [WIDTH-1:0] head;
    logic [CW-1:0]    count;

    fifo_chk_model #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_model (
        .clk     (clk),
        .rst     (rst),
        .write_i (write),
        .read_i  (read),
        .wdata_i (wData),
        .wr_ok_o (wr_ok),
        .rd_ok_o (rd_ok),
        .head_o  (head),
        .count_o (count)
    );

    logic             armed_q;
    logic             rd_pend_q;
    logic [WIDTH-1:0] exp_data_q;
    logic             err_valid_q;
    err_code_e        err_code_q, first_err_q, code_d;
    logic [CNT_W-1:0] err_count_q;
    fail_vec_t        fails;
    logic             fail_any;

    always_comb begin
        fails            = '0;
        fails.data       = (RD_LATENCY == 0) ? (rd_ok && (rdData != head))
                                             : (rd_pend_q && (rdData != exp_data_q));
        fails.both_flags = empty && full;
        fails.empty      = empty != (count == '0);
        fails.full       = full  != (count == CW'(DEPTH));
        fails.overflow   = write && (count == CW'(DEPTH));
        fails.underflow  = read  && (count == '0);
        // armed_q stays low for the first cycle after reset release
        fail_any         = armed_q && (fails != '0);
        code_d           = fail_any ? prio_encode(fails) : ERR_NONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed_q     <= 1'b0;
            rd_pend_q   <= 1'b0;
            exp_data_q  <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            first_err_q <= ERR_NONE;
            err_count_q <= '0;
        end else begin
            armed_q     <= 1'b1;
            rd_pend_q   <= rd_ok;
            if (rd_ok) exp_data_q <= head;
            err_valid_q <= fail_any;
            err_code_q  <= code_d;
            if (fail_any && (first_err_q == ERR_NONE)) first_err_q <= code_d;
            if (fail_any && (err_count_q != '1)) err_count_q <= err_count_q + CNT_W'(1);
        end
    end

    assign err_valid   = err_valid_q;
    assign err_code    = err_code_q;
    assign first_err   = first_err_q;
    assign err_count   = err_count_q;
    assign model_count = count;

endmodule

// File: tb/tb_sync_fifo_checker.sv
// tb/tb_sync_fifo_checker.sv - scoreboard bench for sync_fifo_checker (DEPTH=4, RD_LATENCY=1)
module tb_sync_fifo_checker;
    import fifo_chk_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        write = 1'b0, read = 1'b0, empty = 1'b1, full = 1'b0;
    logic [31:0] wData = '0, rdData = '0;

    logic        err_valid, err_valid2;
    err_code_e   err_code, err_code2, first_err, first_err2;
    logic [15:0] err_count;
    logic [1:0]  err_count2;
    logic [2:0]  model_count, model_count2;

    int          n_vec = 0;
    int          n_bad = 0;
    string       phase = "init";
    err_code_e   sb_q[$];
    logic [31:0] vals [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

    sync_fifo_checker #(.WIDTH(32), .DEPTH(4), .RD_LATENCY(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .write(write), .read(read), .wData(wData), .rdData(rdData),
        .empty(empty), .full(full), .err_valid(err_valid), .err_code(err_code),
        .first_err(first_err), .err_count(err_count), .model_count(model_count)
    );

    sync_fifo_checker #(.WIDTH(32), .DEPTH(4), .RD_LATENCY(1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .write(write), .read(read), .wData(wData), .rdData(rdData),
        .empty(empty), .full(full), .err_valid(err_valid2), .err_code(err_code2),
        .first_err(first_err2), .err_count(err_count2), .model_count(model_count2)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s/%s: got 0x%0h want 0x%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic w, input logic r, input logic [31:0] wd, input logic [31:0] rd,
                       input logic e, input logic f, input err_code_e exp);
        err_code_e want;
        write = w; read = r; wData = wd; rdData = rd; empty = e; full = f;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        want = sb_q.pop_front();
        expect_eq("err_code", 32'(err_code), 32'(want));
        expect_eq("err_valid", 32'(err_valid), 32'(want != ERR_NONE));
    endtask

    task automatic do_reset();
        rst = 1'b0; write = 1'b0; read = 1'b0; empty = 1'b1; full = 1'b0;
        #2;
        expect_eq("rst_err_valid", 32'(err_valid), 32'd0);
        expect_eq("rst_err_code", 32'(err_code), 32'(ERR_NONE));
        expect_eq("rst_first_err", 32'(first_err), 32'(ERR_NONE));
        expect_eq("rst_err_count", 32'(err_count), 32'd0);
        expect_eq("rst_model_count", 32'(model_count), 32'd0);
        expect_eq("rst_err_count_sat", 32'(err_count2), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        // Wrong flags in the first cycle after release must stay silent
        cyc(1'b0, 1'b0, 32'h0, 32'h5A5A, 1'b0, 1'b1, ERR_NONE);
    endtask

    initial begin
        #1;
        phase = "reset";
        do_reset();

        phase = "fill_drain";
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, vals[i], 32'h0, i == 0, 1'b0, ERR_NONE);
        expect_eq("count_full", 32'(model_count), 32'd4);
        for (int i = 0; i < 4; i++)
            cyc(1'b0, 1'b1, 32'h0, (i == 0) ? 32'h0 : vals[i-1], 1'b0, i == 0, ERR_NONE);
        expect_eq("count_empty", 32'(model_count), 32'd0);
        cyc(1'b0, 1'b0, 32'h0, vals[3], 1'b1, 1'b0, ERR_NONE);
        expect_eq("err_count_clean", 32'(err_count), 32'd0);

        phase = "bad_data";
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, vals[i], 32'h0, i == 0, 1'b0, ERR_NONE);
        cyc(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, ERR_NONE);
        cyc(1'b0, 1'b1, 32'h0, vals[0], 1'b0, 1'b0, ERR_NONE);
        cyc(1'b0, 1'b1, 32'h0, 32'hDEAD, 1'b0, 1'b0, ERR_DATA);
        cyc(1'b0, 1'b1, 32'h0, vals[2], 1'b0, 1'b0, ERR_NONE);
        cyc(1'b0, 1'b0, 32'h0, vals[3], 1'b1, 1'b0, ERR_NONE);
        expect_eq("first_err_data", 32'(first_err), 32'(ERR_DATA));
        expect_eq("err_count_data", 32'(err_count), 32'd1);

        phase = "overflow";
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, vals[i], 32'h0, i == 0, 1'b0, ERR_NONE);
        cyc(1'b1, 1'b1, 32'h55, 32'h0, 1'b0, 1'b1, ERR_OVERFLOW);
        expect_eq("count_after_ovf", 32'(model_count), 32'd3);
        expect_eq("err_count_ovf", 32'(err_count), 32'd2);
        cyc(1'b0, 1'b1, 32'h0, vals[0], 1'b0, 1'b0, ERR_NONE);
        cyc(1'b0, 1'b1, 32'h0, vals[1], 1'b0, 1'b0, ERR_NONE);
        cyc(1'b0, 1'b1, 32'h0, vals[2], 1'b0, 1'b0, ERR_NONE);
        cyc(1'b0, 1'b0, 32'h0, vals[3], 1'b1, 1'b0, ERR_NONE);
        expect_eq("count_after_drain", 32'(model_count), 32'd0);
        expect_eq("first_err_sticky", 32'(first_err), 32'(ERR_DATA));

        phase = "both_flags";
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, ERR_BOTH_FLAGS);
        expect_eq("err_count_both", 32'(err_count), 32'd5);
        expect_eq("err_count_sat", 32'(err_count2), 32'd3);
        expect_eq("first_err_both", 32'(first_err), 32'(ERR_BOTH_FLAGS));
        expect_eq("first_err_both_sat", 32'(first_err2), 32'(ERR_BOTH_FLAGS));
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, ERR_NONE);
        expect_eq("err_count_sat_hold", 32'(err_count2), 32'd3);

        phase = "mid_reset";
        cyc(1'b1, 1'b0, 32'hA, 32'h0, 1'b1, 1'b0, ERR_NONE);
        cyc(1'b1, 1'b0, 32'hB, 32'h0, 1'b0, 1'b0, ERR_NONE);
        expect_eq("count_two", 32'(model_count), 32'd2);
        cyc(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, ERR_NONE);
        do_reset();
        cyc(1'b0, 1'b1, 32'h0, 32'hBAD, 1'b1, 1'b0, ERR_UNDERFLOW);
        expect_eq("count_after_udf", 32'(model_count), 32'd0);
        expect_eq("first_err_udf", 32'(first_err), 32'(ERR_UNDERFLOW));
        expect_eq("err_count_udf", 32'(err_count), 32'd1);

        phase = "flag_checks";
        cyc(1'b1, 1'b1, 32'h77, 32'h0, 1'b1, 1'b0, ERR_UNDERFLOW);
        expect_eq("count_wr_on_empty", 32'(model_count), 32'd1);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, ERR_EMPTY);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, ERR_FULL);
        cyc(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, ERR_NONE);
        cyc(1'b0, 1'b0, 32'h0, 32'h77, 1'b1, 1'b0, ERR_NONE);
        expect_eq("err_count_final", 32'(err_count), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
